// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: MFC0 reads, MTC0 writes, exception/ERET bookkeeping,
// Count/Compare timer and the Status/Cause/EPC views returned to write-back.
module cp0_regfile (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  raddr,
   output logic [31:0] rdata,
   input  logic        mtc0_we,
   input  logic [4:0]  mtc0_waddr,
   input  logic [31:0] mtc0_wdata,
   input  logic [4:0]  ex_code,
   input  logic [31:0] ex_pc,
   input  logic        slot,
   input  logic [31:0] bad_vaddr,
   input  logic        eret,
   input  logic [5:0]  hw_int,
   output logic [31:0] status,
   output logic [31:0] cause,
   output logic [31:0] epc,
   output logic        int_pending
);

   localparam logic [4:0] NO_EX = 5'h1f;
   localparam logic [4:0] ADEL  = 5'h04;
   localparam logic [4:0] ADES  = 5'h05;

   localparam logic [4:0] A_BADVADDR = 5'd8;
   localparam logic [4:0] A_COUNT    = 5'd9;
   localparam logic [4:0] A_COMPARE  = 5'd11;
   localparam logic [4:0] A_STATUS   = 5'd12;
   localparam logic [4:0] A_CAUSE    = 5'd13;
   localparam logic [4:0] A_EPC      = 5'd14;

   logic [7:0]  im_q, im_d;
   logic        exl_q, exl_d;
   logic        ie_q, ie_d;
   logic        bd_q, bd_d;
   logic        ti_q, ti_d;
   logic [5:0]  hw_q, hw_d;
   logic [1:0]  ip_sw_q, ip_sw_d;
   logic [4:0]  exccode_q, exccode_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] badvaddr_q, badvaddr_d;
   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic        tick_q, tick_d;

   logic exc, eret_ok, wr;

   always_comb begin
      exc     = (ex_code != NO_EX);
      eret_ok = eret & ~exc;
      wr      = mtc0_we & ~exc;

      im_d       = im_q;
      exl_d      = exl_q;
      ie_d       = ie_q;
      bd_d       = bd_q;
      ti_d       = ti_q;
      ip_sw_d    = ip_sw_q;
      exccode_d  = exccode_q;
      epc_d      = epc_q;
      badvaddr_d = badvaddr_q;
      compare_d  = compare_q;
      tick_d     = ~tick_q;
      count_d    = count_q + {31'b0, tick_q};
      hw_d       = hw_int;

      if (count_q == compare_q) ti_d = 1'b1;

      // A Compare write clears TI even when the match would have set it.
      if (wr) begin
         case (mtc0_waddr)
            A_COUNT:   count_d = mtc0_wdata;
            A_COMPARE: begin
               compare_d = mtc0_wdata;
               ti_d      = 1'b0;
            end
            A_STATUS: begin
               im_d  = mtc0_wdata[15:8];
               exl_d = mtc0_wdata[1];
               ie_d  = mtc0_wdata[0];
            end
            A_CAUSE:   ip_sw_d = mtc0_wdata[9:8];
            A_EPC:     epc_d   = mtc0_wdata;
            default:   ;
         endcase
      end

      if (eret_ok) exl_d = 1'b0;

      // Nested exceptions keep the original return point and BD.
      if (exc) begin
         exl_d     = 1'b1;
         exccode_d = ex_code;
         if (!exl_q) begin
            bd_d  = slot;
            epc_d = slot ? ex_pc - 32'd4 : ex_pc;
         end
         if (ex_code == ADEL || ex_code == ADES) badvaddr_d = bad_vaddr;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         im_q       <= 8'h00;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         ti_q       <= 1'b0;
         hw_q       <= 6'h00;
         ip_sw_q    <= 2'b00;
         exccode_q  <= 5'h00;
         epc_q      <= 32'h0;
         badvaddr_q <= 32'h0;
         count_q    <= 32'h0;
         compare_q  <= 32'h0;
         tick_q     <= 1'b0;
      end else begin
         im_q       <= im_d;
         exl_q      <= exl_d;
         ie_q       <= ie_d;
         bd_q       <= bd_d;
         ti_q       <= ti_d;
         hw_q       <= hw_d;
         ip_sw_q    <= ip_sw_d;
         exccode_q  <= exccode_d;
         epc_q      <= epc_d;
         badvaddr_q <= badvaddr_d;
         count_q    <= count_d;
         compare_q  <= compare_d;
         tick_q     <= tick_d;
      end
   end

   assign status = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
   assign cause  = {bd_q, ti_q, 14'b0, hw_q[5] | ti_q, hw_q[4:0], ip_sw_q,
                    1'b0, exccode_q, 2'b0};
   assign epc    = epc_q;

   assign int_pending = (|(cause[15:8] & status[15:8])) & ~exl_q & ie_q;

   always_comb begin
      rdata = 32'h0;
      case (raddr)
         A_BADVADDR: rdata = badvaddr_q;
         A_COUNT:    rdata = count_q;
         A_COMPARE:  rdata = compare_q;
         A_STATUS:   rdata = status;
         A_CAUSE:    rdata = cause;
         A_EPC:      rdata = epc_q;
         default:    rdata = 32'h0;
      endcase
   end

endmodule

// File: tb/tb_cp0_regfile.sv
// Bench for cp0_regfile: vector table with a read-back scoreboard, plus hand
// sequences for reset, timer, interrupts and same-cycle priority.
module tb_cp0_regfile;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  raddr;
   logic [31:0] rdata;
   logic        mtc0_we;
   logic [4:0]  mtc0_waddr;
   logic [31:0] mtc0_wdata;
   logic [4:0]  ex_code;
   logic [31:0] ex_pc;
   logic        slot;
   logic [31:0] bad_vaddr;
   logic        eret;
   logic [5:0]  hw_int;
   logic [31:0] status, cause, epc;
   logic        int_pending;

   int checks = 0;
   int errors = 0;

   cp0_regfile dut (
      .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata),
      .mtc0_we(mtc0_we), .mtc0_waddr(mtc0_waddr), .mtc0_wdata(mtc0_wdata),
      .ex_code(ex_code), .ex_pc(ex_pc), .slot(slot), .bad_vaddr(bad_vaddr),
      .eret(eret), .hw_int(hw_int), .status(status), .cause(cause), .epc(epc),
      .int_pending(int_pending)
   );

   always #5 clk = ~clk;

   localparam logic [4:0] NO_EX = 5'h1f;
   localparam logic [4:0] INT   = 5'h00;
   localparam logic [4:0] ADEL  = 5'h04;
   localparam logic [4:0] ADES  = 5'h05;

   typedef struct {
      string       nm;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [4:0]  ex;
      logic [31:0] pc;
      logic        sl;
      logic [31:0] bva;
      logic        er;
      logic [4:0]  ra;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      string       nm;
      logic [4:0]  ra;
      logic [31:0] exp;
   } sb_t;

   vec_t vecs[21];
   sb_t  sbq[$];

   function automatic vec_t mk(string nm, logic we, logic [4:0] wa, logic [31:0] wd,
                               logic [4:0] ex, logic [31:0] pc, logic sl,
                               logic [31:0] bva, logic er, logic [4:0] ra,
                               logic [31:0] exp);
      vec_t v;
      v.nm = nm; v.we = we; v.waddr = wa; v.wdata = wd; v.ex = ex; v.pc = pc;
      v.sl = sl; v.bva = bva; v.er = er; v.ra = ra; v.exp = exp;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      mtc0_we = 1'b0; mtc0_waddr = 5'd0; mtc0_wdata = 32'h0;
      ex_code = NO_EX; ex_pc = 32'h0; slot = 1'b0; bad_vaddr = 32'h0; eret = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      mtc0_we = 1'b1; mtc0_waddr = a; mtc0_wdata = d;
      step();
      idle_inputs();
   endtask

   task automatic rd(input string nm, input logic [4:0] a, input logic [31:0] exp);
      raddr = a;
      #1;
      chk(nm, rdata, exp);
   endtask

   initial begin
      sb_t s;
      bit  seen;
      idle_inputs();
      raddr  = 5'd0;
      hw_int = 6'd0;
      reset  = 1'b1;
      step();
      step();
      chk("rst_status", status, 32'h0040_0000);
      chk("rst_cause", cause, 32'h0);
      chk("rst_intp", {31'b0, int_pending}, 32'h0);
      rd("rst_count", 5'd9, 32'h0);

      reset = 1'b0;
      repeat (6) step();
      rd("count_6cyc", 5'd9, 32'd3);
      rd("status_6cyc", 5'd12, 32'h0040_0000);

      vecs[0]  = mk("cmp_wr",     1, 11, 32'hffff_0000, NO_EX, 0, 0, 0, 0, 11, 32'hffff_0000);
      vecs[1]  = mk("st_wr",      1, 12, 32'h0000_ff01, NO_EX, 0, 0, 0, 0, 12, 32'h0040_ff01);
      vecs[2]  = mk("adel_epc",   0, 0, 0, ADEL, 32'hbfc0_0010, 1, 32'h1234_5671, 0, 14, 32'hbfc0_000c);
      vecs[3]  = mk("adel_cause", 0, 0, 0, NO_EX, 0, 0, 0, 0, 13, 32'h8000_0010);
      vecs[4]  = mk("adel_bva",   0, 0, 0, NO_EX, 0, 0, 0, 0, 8, 32'h1234_5671);
      vecs[5]  = mk("adel_st",    0, 0, 0, NO_EX, 0, 0, 0, 0, 12, 32'h0040_ff03);
      vecs[6]  = mk("ades_epc",   0, 0, 0, ADES, 32'h100, 0, 32'h0000_0abc, 0, 14, 32'hbfc0_000c);
      vecs[7]  = mk("ades_cause", 0, 0, 0, NO_EX, 0, 0, 0, 0, 13, 32'h8000_0014);
      vecs[8]  = mk("ades_bva",   0, 0, 0, NO_EX, 0, 0, 0, 0, 8, 32'h0000_0abc);
      vecs[9]  = mk("eret",       0, 0, 0, NO_EX, 0, 0, 0, 1, 12, 32'h0040_ff01);
      vecs[10] = mk("bva_ro",     1, 8, 32'hffff_ffff, NO_EX, 0, 0, 0, 0, 8, 32'h0000_0abc);
      vecs[11] = mk("cause_wr",   1, 13, 32'hffff_ffff, NO_EX, 0, 0, 0, 0, 13, 32'h8000_0314);
      vecs[12] = mk("unmapped0",  0, 0, 0, NO_EX, 0, 0, 0, 0, 0, 32'h0);
      vecs[13] = mk("cnt_wr",     1, 9, 32'hffff_ffff, NO_EX, 0, 0, 0, 0, 9, 32'hffff_ffff);
      vecs[14] = mk("unmapped31", 0, 0, 0, NO_EX, 0, 0, 0, 0, 31, 32'h0);
      vecs[15] = mk("cnt_wrap",   0, 0, 0, NO_EX, 0, 0, 0, 0, 9, 32'h0);
      vecs[16] = mk("cause_clr",  1, 13, 32'h0, NO_EX, 0, 0, 0, 0, 13, 32'h8000_0014);
      vecs[17] = mk("ex_eret_st", 0, 0, 0, INT, 32'h200, 0, 0, 1, 12, 32'h0040_ff03);
      vecs[18] = mk("ex_eret_epc",0, 0, 0, NO_EX, 0, 0, 0, 0, 14, 32'h200);
      vecs[19] = mk("int_cause",  0, 0, 0, NO_EX, 0, 0, 0, 0, 13, 32'h0);
      vecs[20] = mk("eret2",      0, 0, 0, NO_EX, 0, 0, 0, 1, 12, 32'h0040_ff01);

      foreach (vecs[i]) begin
         mtc0_we = vecs[i].we; mtc0_waddr = vecs[i].waddr; mtc0_wdata = vecs[i].wdata;
         ex_code = vecs[i].ex; ex_pc = vecs[i].pc; slot = vecs[i].sl;
         bad_vaddr = vecs[i].bva; eret = vecs[i].er;
         sbq.push_back('{vecs[i].nm, vecs[i].ra, vecs[i].exp});
         step();
         idle_inputs();
         s = sbq.pop_front();
         rd(s.nm, s.ra, s.exp);
      end

      // Timer: TI and int_pending after Count reaches Compare.
      mtc0(5'd9, 32'd0);
      mtc0(5'd11, 32'd10);
      mtc0(5'd12, 32'h0000_8001);
      chk("ti_pre", {31'b0, cause[30]}, 32'h0);
      chk("intp_pre", {31'b0, int_pending}, 32'h0);
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         step();
         if (int_pending) seen = 1'b1;
      end
      chk("ti_seen", {31'b0, seen}, 32'h1);
      chk("ti_set", {31'b0, cause[30]}, 32'h1);
      raddr = 5'd9;
      #1;
      chk("ti_count", {31'b0, (rdata == 32'd10 || rdata == 32'd11)}, 32'h1);
      mtc0(5'd11, 32'd100);
      chk("ti_clr", {31'b0, cause[30]}, 32'h0);
      chk("ti_intp_clr", {31'b0, int_pending}, 32'h0);

      // Hardware interrupt line 0 through IM2.
      mtc0(5'd12, 32'h0000_0401);
      hw_int = 6'b000001;
      #1;
      chk("hw_pre", {31'b0, int_pending}, 32'h0);
      step();
      chk("hw_ip2", {31'b0, cause[10]}, 32'h1);
      chk("hw_intp", {31'b0, int_pending}, 32'h1);
      mtc0(5'd12, 32'h0000_0403);
      chk("hw_exl_mask", {31'b0, int_pending}, 32'h0);
      hw_int = 6'd0;

      // Exception beats a same-cycle MTC0 to EPC.
      mtc0(5'd12, 32'h0000_0001);
      mtc0_we = 1'b1; mtc0_waddr = 5'd14; mtc0_wdata = 32'hdead_beef;
      ex_code = INT; ex_pc = 32'h80;
      step();
      idle_inputs();
      chk("ex_vs_mtc0_epc", epc, 32'h80);
      chk("ex_vs_mtc0_st", status, 32'h0040_0003);

      // Reset beats a same-cycle exception.
      reset = 1'b1;
      ex_code = ADEL; ex_pc = 32'h44; slot = 1'b1; bad_vaddr = 32'h55;
      step();
      reset = 1'b0;
      idle_inputs();
      chk("rx_status", status, 32'h0040_0000);
      chk("rx_cause", cause, 32'h0);
      chk("rx_epc", epc, 32'h0);
      chk("rx_intp", {31'b0, int_pending}, 32'h0);
      rd("rx_bva", 5'd8, 32'h0);
      rd("rx_count", 5'd9, 32'h0);
      rd("rx_compare", 5'd11, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
